// File: rtl/matrix_loader.sv
// Front-end of the matrix coprocessor ALU: takes one command, a row-major element stream,
// drives the ALU and holds its result. Optional EXEC watchdog: define LOADER_TIMEOUT_EN.
module matrix_loader #(
  parameter int N_MAX = 5,
  parameter int W     = 8
`ifdef LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 255
`endif
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [2:0]               cmd_opcode,
  input  logic [2:0]               cmd_size,
  input  logic [W-1:0]             cmd_scalar,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  output logic [N_MAX*N_MAX*W-1:0] A_flat,
  output logic [N_MAX*N_MAX*W-1:0] B_flat,
  output logic [W-1:0]             f,
  output logic [2:0]               opcode,
  input  logic                     alu_done,
  input  logic [N_MAX*N_MAX*W-1:0] C_flat,
  input  logic                     overflow_flag,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [N_MAX*N_MAX*W-1:0] res_flat,
  output logic                     res_ovf,
  output logic                     err,
  output logic [2:0]               state_dbg
);

  // All three ports (cmd, in, res) transfer exactly on a cycle where valid && ready at the
  // rising clock edge; ready depends only on state, never on the partner's valid.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  localparam logic [2:0] N_MAX3 = 3'(N_MAX);

  state_t     state_q, state_d;
  logic [2:0] op_q;
  logic [2:0] n_q;
  logic [2:0] r_q, c_q;
  logic       exec_armed;
  logic       cmd_legal;
  logic       cmd_fire;
  logic       in_fire;
  logic       last_elem;
  logic       row_end;
  logic       binary_op;
  logic       exec_done;
  logic       timeout_hit;
  int         elem_off;

  assign cmd_legal = (cmd_size != 3'd0) && (cmd_size <= N_MAX3) && (cmd_opcode != 3'b000);
  assign cmd_fire  = cmd_valid && (state_q == S_IDLE);
  assign in_fire   = in_valid && ((state_q == S_LOAD_A) || (state_q == S_LOAD_B));
  assign row_end   = (c_q == n_q - 3'd1);
  assign last_elem = row_end && (r_q == n_q - 3'd1);
  assign binary_op = (op_q == 3'b001) || (op_q == 3'b010) || (op_q == 3'b011);
  // The first EXEC cycle may still see done from the previous operation.
  assign exec_done = exec_armed && alu_done;
  assign elem_off  = (int'(r_q) * N_MAX + int'(c_q)) * W;
  assign state_dbg = state_q;

`ifdef LOADER_TIMEOUT_EN
  logic [7:0] tmo_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tmo_q <= 8'd0;
    end else begin
      tmo_q <= (state_q == S_EXEC) ? tmo_q + 8'd1 : 8'd0;
    end
  end

  assign timeout_hit = (state_q == S_EXEC) && (tmo_q == 8'(TIMEOUT - 1)) && !exec_done;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    opcode    = 3'b000;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_fire && cmd_legal) state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        in_ready = 1'b1;
        if (in_fire && last_elem) state_d = binary_op ? S_LOAD_B : S_EXEC;
      end
      S_LOAD_B: begin
        in_ready = 1'b1;
        if (in_fire && last_elem) state_d = S_EXEC;
      end
      S_EXEC: begin
        opcode = op_q;
        if (exec_done) state_d = S_RESULT;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      op_q       <= 3'b000;
      n_q        <= 3'd0;
      r_q        <= 3'd0;
      c_q        <= 3'd0;
      f          <= '0;
      A_flat     <= '0;
      B_flat     <= '0;
      res_flat   <= '0;
      res_ovf    <= 1'b0;
      err        <= 1'b0;
      exec_armed <= 1'b0;
    end else begin
      err        <= timeout_hit;
      exec_armed <= (state_q == S_EXEC) && (state_d == S_EXEC);
      if (cmd_fire) begin
        if (cmd_legal) begin
          op_q   <= cmd_opcode;
          n_q    <= cmd_size;
          f      <= cmd_scalar;
          A_flat <= '0;
          B_flat <= '0;
          r_q    <= 3'd0;
          c_q    <= 3'd0;
        end else begin
          err <= 1'b1;
        end
      end
      if (in_fire) begin
        if (state_q == S_LOAD_A) A_flat[elem_off +: W] <= in_data;
        else B_flat[elem_off +: W] <= in_data;
        // Wrap both counters after the last element so LOAD_B restarts at (0,0).
        if (last_elem) begin
          r_q <= 3'd0;
          c_q <= 3'd0;
        end else if (row_end) begin
          r_q <= r_q + 3'd1;
          c_q <= 3'd0;
        end else begin
          c_q <= c_q + 3'd1;
        end
      end
      if ((state_q == S_EXEC) && exec_done) begin
        res_flat <= C_flat;
        res_ovf  <= overflow_flag;
      end
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Directed and randomized bench for matrix_loader with a behavioural ALU stub that raises
// done one cycle after the opcode changes.
module tb_matrix_loader;

  localparam int FW = 200;

  logic          clock = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [2:0]    cmd_opcode, cmd_size;
  logic [7:0]    cmd_scalar;
  logic          in_valid, in_ready;
  logic [7:0]    in_data;
  logic [FW-1:0] A_flat, B_flat, C_flat, res_flat;
  logic [7:0]    f;
  logic [2:0]    opcode;
  logic          alu_done, overflow_flag;
  logic          res_valid, res_ready, res_ovf, err;
  logic [2:0]    state_dbg;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [FW-1:0] exp_q[$];
  logic          ovf_q[$];
  logic [7:0]    a_m[5][5];
  logic [7:0]    b_m[5][5];
  logic          stale_done = 1'b0;
  logic          done_r;
  logic [2:0]    prev_op;

  matrix_loader dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_size(cmd_size), .cmd_scalar(cmd_scalar),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .A_flat(A_flat), .B_flat(B_flat), .f(f), .opcode(opcode),
    .alu_done(alu_done), .C_flat(C_flat), .overflow_flag(overflow_flag),
    .res_valid(res_valid), .res_ready(res_ready), .res_flat(res_flat),
    .res_ovf(res_ovf), .err(err), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  // ---------------- behavioural ALU ----------------
  function automatic logic [FW:0] stub_alu(input logic [2:0] op, input logic [FW-1:0] a,
                                           input logic [FW-1:0] b, input logic [7:0] s);
    logic [FW-1:0] c;
    logic          o;
    int            x, y, z;
    c = '0;
    o = 1'b0;
    for (int i = 0; i < 25; i++) begin
      x = int'($signed(a[i*8 +: 8]));
      y = int'($signed(b[i*8 +: 8]));
      case (op)
        3'd1:    z = x + y;
        3'd2:    z = x - y;
        3'd3:    z = x ^ y;
        3'd4:    z = -x;
        3'd5:    z = ~x;
        3'd6:    z = x * int'($signed(s));
        default: z = x;
      endcase
      if ((op == 3'd1 || op == 3'd2 || op == 3'd6) && (z > 127 || z < -128)) o = 1'b1;
      c[i*8 +: 8] = z[7:0];
    end
    return {o, c};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_op       <= 3'b000;
      done_r        <= 1'b0;
      C_flat        <= '0;
      overflow_flag <= 1'b0;
    end else begin
      prev_op <= opcode;
      done_r  <= (opcode != 3'b000) && (opcode != prev_op);
      if ((opcode != 3'b000) && (opcode != prev_op))
        {overflow_flag, C_flat} <= stub_alu(opcode, A_flat, B_flat, f);
    end
  end

  assign alu_done = done_r | stale_done;

  // ---------------- reference model ----------------
  function automatic logic [FW-1:0] build_flat(input bit use_b, input int n);
    logic [FW-1:0] v;
    v = '0;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        v[(r*5+c)*8 +: 8] = use_b ? b_m[r][c] : a_m[r][c];
    return v;
  endfunction

  // ---------------- checking and drivers ----------------
  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [2:0] sz, input logic [7:0] sc,
                          input bit with_byte);
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    cmd_size   = sz;
    cmd_scalar = sc;
    if (with_byte) begin
      in_valid = 1'b1;
      in_data  = 8'hAA;
    end
    chk("cmd_ready_idle", cmd_ready, 1);
    tick();
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic send_elem(input logic [7:0] b, input int stall);
    int k;
    for (int i = 0; i < stall; i++) tick();
    in_valid = 1'b1;
    in_data  = b;
    k = 0;
    while (in_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (k >= 50) chk("in_ready_wait", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  function automatic int pick_stall(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  task automatic fill_random(input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        a_m[r][c] = 8'($urandom_range(0, 255));
        b_m[r][c] = 8'($urandom_range(0, 255));
      end
  endtask

  task automatic run_op(input logic [2:0] op, input int n, input logic [7:0] sc,
                        input int stall_mode, input int hold, input bit with_byte);
    logic [FW-1:0] ea, eb, er;
    logic          eo;
    bit            bin;
    int            k;
    bin = (op == 3'd1 || op == 3'd2 || op == 3'd3);
    ea  = build_flat(1'b0, n);
    eb  = bin ? build_flat(1'b1, n) : '0;
    {eo, er} = stub_alu(op, ea, eb, sc);
    exp_q.push_back(er);
    ovf_q.push_back(eo);

    send_cmd(op, 3'(n), sc, with_byte);
    chk("cmd_to_in_ready", in_ready, 1);
    chk("f_latched", f, sc);
    chk("a_cleared", A_flat, 0);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) send_elem(a_m[r][c], pick_stall(stall_mode));
    if (bin) begin
      chk("opcode_in_load", opcode, 0);
      chk("a_flat_mid", A_flat, ea);
      chk("in_ready_load_b", in_ready, 1);
      for (int r = 0; r < n; r++)
        for (int c = 0; c < n; c++) send_elem(b_m[r][c], pick_stall(stall_mode));
    end
    chk("opcode_exec", opcode, op);
    chk("a_flat", A_flat, ea);
    chk("b_flat", B_flat, eb);
    chk("in_ready_exec", in_ready, 0);
    tick();
    chk("opcode_exec_cycle2", opcode, op);

    k = 0;
    while (res_valid !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("res_valid_seen", res_valid, 1);
    er = exp_q.pop_front();
    eo = ovf_q.pop_front();
    chk("res_flat", res_flat, er);
    chk("res_ovf", res_ovf, eo);
    chk("opcode_after_done", opcode, 0);

    if (hold > 0) begin
      cmd_valid  = 1'b1;
      cmd_opcode = 3'd1;
      cmd_size   = 3'd1;
      for (int i = 0; i < hold; i++) begin
        tick();
        chk("hold_res_valid", res_valid, 1);
        chk("hold_res_flat", res_flat, er);
        chk("hold_cmd_ready", cmd_ready, 0);
      end
      cmd_valid = 1'b0;
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("res_valid_drop", res_valid, 0);
    chk("back_to_idle", cmd_ready, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [2:0] bad_op[3];
    logic [2:0] bad_sz[3];
    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_opcode = 3'd0;
    cmd_size   = 3'd0;
    cmd_scalar = 8'd0;
    in_valid   = 1'b0;
    in_data    = 8'd0;
    res_ready  = 1'b0;
    #3;
    chk("rst_a_flat", A_flat, 0);
    chk("rst_b_flat", B_flat, 0);
    chk("rst_res_flat", res_flat, 0);
    chk("rst_f", f, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_ovf", res_ovf, 0);
    chk("rst_err", err, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // add n=2
    a_m[0][0] = 8'd1; a_m[0][1] = 8'd2; a_m[1][0] = 8'd3; a_m[1][1] = 8'd4;
    b_m[0][0] = 8'd5; b_m[0][1] = 8'd6; b_m[1][0] = 8'd7; b_m[1][1] = 8'd8;
    run_op(3'd1, 2, 8'd0, 0, 0, 1'b0);
    chk("t1_a_byte6", A_flat[55:48], 4);
    chk("t1_a_byte2", A_flat[23:16], 0);
    chk("t1_res_byte0", res_flat[7:0], 6);
    chk("t1_res_byte1", res_flat[15:8], 8);
    chk("t1_res_byte5", res_flat[47:40], 10);
    chk("t1_res_byte6", res_flat[55:48], 12);

    // scalar n=3
    for (int i = 0; i < 9; i++) a_m[i/3][i%3] = 8'(i + 1);
    run_op(3'd6, 3, 8'd2, 0, 0, 1'b0);
    chk("t2_res_byte12", res_flat[103:96], 18);
    chk("t2_b_zero", B_flat, 0);

    // n=5 add, one idle cycle before every element
    fill_random(5);
    run_op(3'd1, 5, 8'd0, 1, 0, 1'b0);
    chk("t3_byte24", A_flat[199:192], a_m[4][4]);

    // illegal commands
    bad_op[0] = 3'd1; bad_sz[0] = 3'd0;
    bad_op[1] = 3'd2; bad_sz[1] = 3'd6;
    bad_op[2] = 3'd0; bad_sz[2] = 3'd3;
    for (int i = 0; i < 3; i++) begin
      send_cmd(bad_op[i], bad_sz[i], 8'd0, 1'b0);
      chk("ill_err_pulse", err, 1);
      chk("ill_cmd_ready", cmd_ready, 1);
      chk("ill_in_ready", in_ready, 0);
      tick();
      chk("ill_err_low", err, 0);
    end

    // result backpressure, with a byte offered alongside the command
    fill_random(4);
    run_op(3'd2, 4, 8'd0, 0, 10, 1'b1);

    // stale done held high across a whole operation
    fill_random(3);
    stale_done = 1'b1;
    run_op(3'd5, 3, 8'd0, 0, 0, 1'b0);
    stale_done = 1'b0;

    // reset in the middle of LOAD_B
    fill_random(2);
    send_cmd(3'd1, 3'd2, 8'd0, 1'b0);
    for (int i = 0; i < 4; i++) send_elem(a_m[i/2][i%2], 0);
    for (int i = 0; i < 3; i++) send_elem(b_m[i/2][i%2], 0);
    reset = 1'b1;
    #2;
    chk("mid_rst_a_flat", A_flat, 0);
    chk("mid_rst_b_flat", B_flat, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_opcode", opcode, 0);
    chk("mid_rst_res_flat", res_flat, 0);
    chk("mid_rst_f", f, 0);
    @(posedge clock);
    #1 reset = 1'b0;
    fill_random(2);
    run_op(3'd3, 2, 8'd0, 0, 0, 1'b0);

    // randomized operations
    for (int t = 0; t < 8; t++) begin
      int n;
      n = int'($urandom_range(1, 5));
      fill_random(n);
      run_op(3'($urandom_range(1, 7)), n, 8'($urandom_range(0, 255)), 2,
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
